// File: rtl/pipe_skid_reg.sv
// Two-entry skid register for pipeline stages: a main register drives the output and a skid register absorbs one word when downstream stalls.
// Optional statistics counters (stall_cnt, flush_cnt) are built when PIPE_SKID_STATS_EN is defined.
module pipe_skid_reg #(
  parameter int                 DATA_W   = 64,
  parameter logic [DATA_W-1:0]  NOP_DATA = {DATA_W{1'b0}},
  parameter int                 CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_r;
  logic [DATA_W-1:0]   main_r;
  logic [DATA_W-1:0]   skid_r;
  logic                in_fire_s;
  logic                out_fire_s;

  if (DATA_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_skid_reg: DATA_W and CNT_W must be at least 1");
  end

  // Handshake flags come straight from the state register, never from the peer's valid/ready.
  assign out_valid  = (state_r != EMPTY);
  assign in_ready   = (state_r != FULL) & ~Reset;
  assign out_data   = main_r;
  assign occupancy  = state_r;
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;

  // Occupancy state and payload registers; each register loads only on the transitions that need it.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r <= EMPTY;
      main_r  <= NOP_DATA;
      skid_r  <= NOP_DATA;
    end else if (flush) begin
      state_r <= EMPTY;
      main_r  <= NOP_DATA;
      skid_r  <= NOP_DATA;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            state_r <= HALF;
            main_r  <= in_data;
          end
        end
        HALF: begin
          if (in_fire_s && out_fire_s) begin
            main_r  <= in_data;
          end else if (in_fire_s) begin
            state_r <= FULL;
            skid_r  <= in_data;
          end else if (out_fire_s) begin
            state_r <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire_s) begin
            state_r <= HALF;
            main_r  <= skid_r;
          end
        end
        default: begin
          state_r <= EMPTY;
          main_r  <= NOP_DATA;
          skid_r  <= NOP_DATA;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_STATS_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             discard_s;

  // A flush discards something if a held word is not leaving this cycle or a new word is being accepted.
  always_comb begin
    discard_s = 1'b0;
    if (flush) begin
      discard_s = in_fire_s | (occupancy > {1'b0, out_fire_s});
    end else begin
      discard_s = 1'b0;
    end
  end

  // Saturating event counters.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (out_valid && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (discard_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg; statistics checks are compiled in when PIPE_SKID_STATS_EN is defined.
module tb_pipe_skid_reg;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;

  logic              CLK;
  logic              Reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic [1:0]        occupancy;
`ifdef PIPE_SKID_STATS_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pipe_skid_reg #(
    .DATA_W   (DATA_W),
    .NOP_DATA ({DATA_W{1'b0}}),
    .CNT_W    (CNT_W)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 64'h0;
    out_ready = 1'b0;
    flush     = 1'b0;
    step();
    step();

    check("rst_in_ready",  {63'h0, in_ready},  64'h0);
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_occupancy", {62'h0, occupancy}, 64'h0);
    check("rst_out_data",  out_data,           64'h0);
`ifdef PIPE_SKID_STATS_EN
    check("rst_stall_cnt", {60'h0, stall_cnt}, 64'h0);
    check("rst_flush_cnt", {60'h0, flush_cnt}, 64'h0);
`endif
    Reset = 1'b0;
    #1;
    check("post_rst_in_ready", {63'h0, in_ready}, 64'h1);

    // Single word through an empty stage.
    in_valid  = 1'b1;
    in_data   = 64'h0000_0004_2008_0005;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("first_out_valid", {63'h0, out_valid}, 64'h1);
    check("first_out_data",  out_data,           64'h0000_0004_2008_0005);
    check("first_occupancy", {62'h0, occupancy}, 64'h1);
    step();
    check("drain_occupancy", {62'h0, occupancy}, 64'h0);
    check("empty_holds_data", out_data,          64'h0000_0004_2008_0005);

    // Fill both entries while stalled, then drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h11;
    step();
    in_data   = 64'h22;
    step();
    in_valid  = 1'b0;
    check("full_occupancy", {62'h0, occupancy}, 64'h2);
    check("full_in_ready",  {63'h0, in_ready},  64'h0);
    check("full_out_data",  out_data,           64'h11);
    out_ready = 1'b1;
    step();
    check("drain_b_data", out_data,           64'h22);
    check("drain_b_occ",  {62'h0, occupancy}, 64'h1);
    step();
    check("drain_end_occ",   {62'h0, occupancy}, 64'h0);
    check("drain_end_valid", {63'h0, out_valid}, 64'h0);

    // Back-to-back streaming at one word per cycle.
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i);
      check($sformatf("stream_in_ready_%0d", i), {63'h0, in_ready}, 64'h1);
      step();
      check($sformatf("stream_valid_%0d", i), {63'h0, out_valid}, 64'h1);
      check($sformatf("stream_data_%0d", i),  out_data,           64'(i));
    end
    in_valid = 1'b0;
    step();
    check("stream_end_occ", {62'h0, occupancy}, 64'h0);

    // Flush while full with a word offered upstream.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hA;
    step();
    in_data   = 64'hB;
    step();
    in_data   = 64'hC;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    check("flush_valid", {63'h0, out_valid}, 64'h0);
    check("flush_data",  out_data,           64'h0);
    check("flush_occ",   {62'h0, occupancy}, 64'h0);
`ifdef PIPE_SKID_STATS_EN
    check("flush_cnt_full", {60'h0, flush_cnt}, 64'h1);
`endif
    out_ready = 1'b1;
    step();
    check("flush_no_c_valid", {63'h0, out_valid}, 64'h0);

    // Flush in HALF: the held word leaves normally, the accepted word is dropped.
    in_valid = 1'b1;
    in_data  = 64'hD;
    step();
    in_data  = 64'hE;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_half_valid", {63'h0, out_valid}, 64'h0);
    check("flush_half_data",  out_data,           64'h0);
`ifdef PIPE_SKID_STATS_EN
    check("flush_cnt_half", {60'h0, flush_cnt}, 64'h2);
`endif

    // Reset takes priority in FULL.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h31;
    step();
    in_data   = 64'h32;
    step();
    check("pre_rst_occ", {62'h0, occupancy}, 64'h2);
    Reset = 1'b1;
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst_comb_in_ready", {63'h0, in_ready}, 64'h0);
    step();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    check("rst_full_occ",      {62'h0, occupancy}, 64'h0);
    check("rst_full_data",     out_data,           64'h0);
    check("rst_full_in_ready", {63'h0, in_ready},  64'h0);
`ifdef PIPE_SKID_STATS_EN
    check("rst_full_flush_cnt", {60'h0, flush_cnt}, 64'h0);
`endif
    Reset = 1'b0;
    #1;
    check("rst_release_in_ready", {63'h0, in_ready}, 64'h1);

    // Hold one word stalled for 20 cycles.
    in_valid = 1'b1;
    in_data  = 64'h41;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
    end
    check("stall_hold_data",  out_data,           64'h41);
    check("stall_hold_valid", {63'h0, out_valid}, 64'h1);
`ifdef PIPE_SKID_STATS_EN
    check("stall_cnt_sat", {60'h0, stall_cnt}, 64'hF);
`endif
    out_ready = 1'b1;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("idle_flush_occ", {62'h0, occupancy}, 64'h0);
`ifdef PIPE_SKID_STATS_EN
    check("idle_flush_cnt", {60'h0, flush_cnt}, 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
